// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states,
// AXI response code and requester port indices.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_B    = 3'd4,
    ST_RESP = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, on contention
// the port that was not granted last time wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == PORT1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch read port and an LSU read/write port onto
// a single AXI-lite master, one transaction in flight at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      s0_req,
  input  logic [ADDR_WIDTH-1:0]     s0_addr,
  output logic                      s0_done,
  output logic [DATA_WIDTH-1:0]     s0_rdata,
  output logic                      s0_err,

  input  logic                      s1_req,
  input  logic                      s1_we,
  input  logic [ADDR_WIDTH-1:0]     s1_addr,
  input  logic [DATA_WIDTH-1:0]     s1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s1_wstrb,
  output logic                      s1_done,
  output logic [DATA_WIDTH-1:0]     s1_rdata,
  output logic                      s1_err,

  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready,

  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready
);

  state_e                    state_q, state_d;
  logic                      owner_q, owner_d;
  logic                      last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      s0_done_q, s0_done_d;
  logic                      s1_done_q, s1_done_d;
  logic [DATA_WIDTH-1:0]     s0_rdata_q, s0_rdata_d;
  logic [DATA_WIDTH-1:0]     s1_rdata_q, s1_rdata_d;
  logic                      s0_err_q, s0_err_d;
  logic                      s1_err_q, s1_err_d;

  logic [1:0]                grant;
  logic                      grant_port;
  logic                      grant_we;
  logic                      aw_pending;
  logic                      w_pending;
  logic                      resp_fire;
  logic [DATA_WIDTH-1:0]     resp_data;
  logic                      resp_err;

  rr_arbiter2 u_rr (
    .req   ({s1_req, s0_req}),
    .last  (last_grant_q),
    .grant (grant)
  );

  assign grant_port = grant[1];
  assign grant_we   = (grant_port == PORT1) ? s1_we : 1'b0;
  assign aw_pending = awvalid_q & ~m_awready;
  assign w_pending  = wvalid_q & ~m_wready;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    s0_done_d    = 1'b0;
    s1_done_d    = 1'b0;
    s0_rdata_d   = s0_rdata_q;
    s1_rdata_d   = s1_rdata_q;
    s0_err_d     = s0_err_q;
    s1_err_d     = s1_err_q;
    resp_fire    = 1'b0;
    resp_data    = '0;
    resp_err     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          owner_d      = grant_port;
          last_grant_d = grant_port;
          addr_d       = (grant_port == PORT1) ? s1_addr : s0_addr;
          wdata_d      = (grant_port == PORT1) ? s1_wdata : '0;
          wstrb_d      = (grant_port == PORT1) ? s1_wstrb : '0;
          if (grant_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_AW;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_AR;
          end
        end
      end
      ST_AR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_R;
        end
      end
      ST_R: begin
        if (m_rvalid) begin
          rready_d  = 1'b0;
          resp_fire = 1'b1;
          resp_data = m_rdata;
          resp_err  = (m_rresp != RESP_OKAY);
        end
      end
      ST_AW: begin
        // Address and data channels retire independently; B waits for both.
        awvalid_d = aw_pending;
        wvalid_d  = w_pending;
        if (!aw_pending && !w_pending) begin
          bready_d = 1'b1;
          state_d  = ST_B;
        end
      end
      ST_B: begin
        if (m_bvalid) begin
          bready_d  = 1'b0;
          resp_fire = 1'b1;
          resp_err  = (m_bresp != RESP_OKAY);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (resp_fire) begin
      state_d = ST_RESP;
      if (owner_q == PORT1) begin
        s1_done_d  = 1'b1;
        s1_rdata_d = resp_data;
        s1_err_d   = resp_err;
      end else begin
        s0_done_d  = 1'b1;
        s0_rdata_d = resp_data;
        s0_err_d   = resp_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT0;
      last_grant_q <= PORT1;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      s0_done_q    <= 1'b0;
      s1_done_q    <= 1'b0;
      s0_rdata_q   <= '0;
      s1_rdata_q   <= '0;
      s0_err_q     <= 1'b0;
      s1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      s0_done_q    <= s0_done_d;
      s1_done_q    <= s1_done_d;
      s0_rdata_q   <= s0_rdata_d;
      s1_rdata_q   <= s1_rdata_d;
      s0_err_q     <= s0_err_d;
      s1_err_q     <= s1_err_d;
    end
  end

  assign m_araddr  = addr_q;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;
  assign m_awaddr  = addr_q;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign s0_done   = s0_done_q;
  assign s0_rdata  = s0_rdata_q;
  assign s0_err    = s0_err_q;
  assign s1_done   = s1_done_q;
  assign s1_rdata  = s1_rdata_q;
  assign s1_err    = s1_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions
// against a scripted AXI-lite slave, plus contention and reset sequences.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          s0_req;
  logic [AW-1:0] s0_addr;
  logic          s0_done;
  logic [DW-1:0] s0_rdata;
  logic          s0_err;
  logic          s1_req;
  logic          s1_we;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_wdata;
  logic [7:0]    s1_wstrb;
  logic          s1_done;
  logic [DW-1:0] s1_rdata;
  logic          s1_err;
  logic [AW-1:0] m_araddr;
  logic          m_arvalid;
  logic          m_arready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rvalid;
  logic          m_rready;
  logic [AW-1:0] m_awaddr;
  logic          m_awvalid;
  logic          m_awready;
  logic [DW-1:0] m_wdata;
  logic [7:0]    m_wstrb;
  logic          m_wvalid;
  logic          m_wready;
  logic [1:0]    m_bresp;
  logic          m_bvalid;
  logic          m_bready;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s0_req(s0_req), .s0_addr(s0_addr), .s0_done(s0_done), .s0_rdata(s0_rdata), .s0_err(s0_err),
    .s1_req(s1_req), .s1_we(s1_we), .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_done(s1_done), .s1_rdata(s1_rdata), .s1_err(s1_err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [7:0]    wstrb;
    logic [DW-1:0] sl_rdata;
    logic [1:0]    sl_resp;
    int            ar_dly;
    int            r_dly;
    int            aw_dly;
    int            w_dly;
    int            exp_lat;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_slave();
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    s0_req = 1'b0;
    s1_req = 1'b0;
    clear_slave();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Drives one request and plays the slave with the vector's wait states.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc, ar_c, r_c, aw_c, w_c, b_cnt, first_valid;
    bit done_seen, other_done_seen;
    logic [DW-1:0] oth_rdata;
    logic oth_err;
    cyc = 0; ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_cnt = 0; first_valid = -1;
    done_seen = 0; other_done_seen = 0;
    @(negedge clk);
    oth_rdata = v.port ? s0_rdata : s1_rdata;
    oth_err   = v.port ? s0_err : s1_err;
    if (v.port) begin
      s1_req = 1'b1; s1_we = v.we; s1_addr = v.addr; s1_wdata = v.wdata; s1_wstrb = v.wstrb;
    end else begin
      s0_req = 1'b1; s0_addr = v.addr;
    end
    while (!done_seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      clear_slave();
      if (m_arvalid) begin
        if (first_valid < 0) first_valid = cyc;
        if (ar_c == v.ar_dly) begin
          check("araddr", DW'(m_araddr), DW'(v.addr));
          m_arready = 1'b1;
        end
        ar_c++;
      end
      if (m_rready) begin
        if (r_c == v.r_dly) begin
          m_rvalid = 1'b1; m_rdata = v.sl_rdata; m_rresp = v.sl_resp;
        end
        r_c++;
      end
      if (m_awvalid) begin
        if (first_valid < 0) first_valid = cyc;
        if (aw_c == v.aw_dly) begin
          check("awaddr", DW'(m_awaddr), DW'(v.addr));
          m_awready = 1'b1;
        end
        aw_c++;
      end
      if (m_wvalid) begin
        if (w_c == v.w_dly) begin
          check("wdata", m_wdata, v.wdata);
          check("wstrb", DW'(m_wstrb), DW'(v.wstrb));
          m_wready = 1'b1;
        end
        w_c++;
      end
      if (m_bready) begin
        m_bvalid = 1'b1; m_bresp = v.sl_resp; b_cnt++;
      end
      if (v.port ? s0_done : s1_done) other_done_seen = 1;
      if (v.port ? s1_done : s0_done) begin
        done_seen = 1;
        check("latency", DW'(cyc), DW'(v.exp_lat));
        check("rdata", v.port ? s1_rdata : s0_rdata, v.exp_rdata);
        check("err", DW'(v.port ? s1_err : s0_err), DW'(v.exp_err));
        s0_req = 1'b0;
        s1_req = 1'b0;
      end
    end
    if (!done_seen) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: vector %0d no done after %0d cycles, required one", idx, cyc);
      s0_req = 1'b0; s1_req = 1'b0;
    end
    check("first_valid_cycle", DW'(first_valid), DW'(1));
    if (v.we) begin
      check("aw_valid_cycles", DW'(aw_c), DW'(v.aw_dly + 1));
      check("w_valid_cycles", DW'(w_c), DW'(v.w_dly + 1));
      check("b_handshakes", DW'(b_cnt), DW'(1));
    end else begin
      check("ar_valid_cycles", DW'(ar_c), DW'(v.ar_dly + 1));
      check("r_ready_cycles", DW'(r_c), DW'(v.r_dly + 1));
    end
    check("other_done", DW'(other_done_seen), DW'(0));
    check("other_rdata_hold", v.port ? s0_rdata : s1_rdata, oth_rdata);
    check("other_err_hold", DW'(v.port ? s0_err : s1_err), DW'(oth_err));
    @(negedge clk);
    clear_slave();
    check("done_one_cycle", DW'(v.port ? s1_done : s0_done), DW'(0));
    check("rdata_hold", v.port ? s1_rdata : s0_rdata, v.exp_rdata);
    check("err_hold", DW'(v.port ? s1_err : s0_err), DW'(v.exp_err));
    $display("txn %0d: port %0d %s addr 0x%0h latency %0d rdata 0x%0h err %0d",
             idx, v.port, v.we ? "write" : "read", v.addr, cyc,
             v.port ? s1_rdata : s0_rdata, v.port ? s1_err : s0_err);
  endtask

  vec_t vecs[7];
  int   order[4];
  int   exp_order[4];
  int   n_done;
  int   guard;
  logic [AW-1:0] last_ar;
  bit   in_r;
  bit   stray_done;

  initial begin
    rst = 1'b0; s0_req = 1'b0; s0_addr = '0;
    s1_req = 1'b0; s1_we = 1'b0; s1_addr = '0; s1_wdata = '0; s1_wstrb = '0;
    m_rdata = '0; m_rresp = 2'b00; m_bresp = 2'b00;
    clear_slave();

    //           port we  addr          wdata                   strb   sl_rdata                resp  ar r aw w lat exp_rdata               err
    vecs[0] = '{1'b0, 1'b0, 32'h80000000, 64'h0,                  8'h00, 64'h1122334455667788, 2'b00, 0, 0, 0, 0, 3, 64'h1122334455667788, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'ha00003f8, 64'h41,                 8'h01, 64'h0,                2'b00, 0, 0, 0, 2, 5, 64'h0,                1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h00001000, 64'hdeadbeefcafef00d,   8'hff, 64'h0,                2'b00, 0, 0, 0, 0, 3, 64'h0,                1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h00002000, 64'h0,                  8'h00, 64'h00000000000055aa, 2'b10, 0, 0, 0, 0, 3, 64'h00000000000055aa, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h00003000, 64'h0,                  8'h00, 64'hfedcba9876543210, 2'b00, 2, 1, 0, 0, 6, 64'hfedcba9876543210, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h00004008, 64'h0123456789abcdef,   8'hf0, 64'h0,                2'b11, 0, 0, 1, 0, 4, 64'h0,                1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'h00005000, 64'h0,                  8'h00, 64'h0000000077778888, 2'b00, 0, 0, 0, 0, 3, 64'h0000000077778888, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_arvalid", DW'(m_arvalid), DW'(0));
    check("rst_awvalid", DW'(m_awvalid), DW'(0));
    check("rst_wvalid", DW'(m_wvalid), DW'(0));
    check("rst_rready", DW'(m_rready), DW'(0));
    check("rst_bready", DW'(m_bready), DW'(0));
    check("rst_s0_done", DW'(s0_done), DW'(0));
    check("rst_s1_done", DW'(s1_done), DW'(0));
    check("rst_s0_rdata", s0_rdata, DW'(0));
    check("rst_s1_rdata", s1_rdata, DW'(0));
    check("rst_s0_err", DW'(s0_err), DW'(0));
    check("rst_s1_err", DW'(s1_err), DW'(0));

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Contention straight after reset: port 0 first, then strict alternation.
    do_reset();
    @(negedge clk);
    s0_req = 1'b1; s0_addr = 32'h100;
    s1_req = 1'b1; s1_we = 1'b0; s1_addr = 32'h200;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    n_done = 0; guard = 0; last_ar = '0;
    while (n_done < 4 && guard < 60) begin
      @(negedge clk);
      guard++;
      clear_slave();
      if (m_arvalid) begin last_ar = m_araddr; m_arready = 1'b1; end
      if (m_rready) begin m_rvalid = 1'b1; m_rdata = DW'(last_ar); m_rresp = 2'b00; end
      if (s0_done) begin
        check("cont_s0_rdata", s0_rdata, DW'(32'h100));
        order[n_done] = 0; n_done++;
      end
      if (s1_done && n_done < 4) begin
        check("cont_s1_rdata", s1_rdata, DW'(32'h200));
        order[n_done] = 1; n_done++;
      end
    end
    s0_req = 1'b0; s1_req = 1'b0;
    check("cont_done_count", DW'(n_done), DW'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cont_order_%0d", i), DW'(order[i]), DW'(exp_order[i]));
      $display("txn contention %0d: port %0d served", i, order[i]);
    end
    @(negedge clk);
    clear_slave();

    // Reset while the R channel is waiting, with rvalid presented that same cycle.
    @(negedge clk);
    s0_req = 1'b1; s0_addr = 32'h300;
    in_r = 0; guard = 0;
    while (!in_r && guard < 10) begin
      @(negedge clk);
      guard++;
      clear_slave();
      if (m_rready) in_r = 1;
      else if (m_arvalid) m_arready = 1'b1;
    end
    check("reach_r_state", DW'(in_r), DW'(1));
    m_rvalid = 1'b1; m_rdata = 64'h99; m_rresp = 2'b00;
    rst = 1'b0; s0_req = 1'b0;
    @(negedge clk);
    m_rvalid = 1'b0;
    rst = 1'b1;
    check("midrst_rready", DW'(m_rready), DW'(0));
    check("midrst_arvalid", DW'(m_arvalid), DW'(0));
    check("midrst_awvalid", DW'(m_awvalid), DW'(0));
    check("midrst_bready", DW'(m_bready), DW'(0));
    check("midrst_s0_done", DW'(s0_done), DW'(0));
    check("midrst_s0_rdata", s0_rdata, DW'(0));
    check("midrst_s1_rdata", s1_rdata, DW'(0));
    stray_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (s0_done || s1_done || m_arvalid) stray_done = 1;
    end
    check("midrst_no_activity", DW'(stray_done), DW'(0));
    $display("txn midreset: abandoned read, s0_rdata 0x%0h", s0_rdata);

    run_vec(7, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: address width on all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: data width; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have port clk  input  1: sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port group s0_req/s0_addr  input  1/ADDR_WIDTH: port 0 (ifetch) read request, level held until s0_done.
REQ-006 SHALL have port group s0_done/s0_rdata/s0_err  output  1/DATA_WIDTH/1: port 0 one-cycle completion, read data, error.
REQ-007 SHALL have port group s1_req/s1_we/s1_addr/s1_wdata/s1_wstrb  input  1/1/ADDR_WIDTH/DATA_WIDTH/8: port 1 (LSU) read or write request.
REQ-008 SHALL have port group s1_done/s1_rdata/s1_err  output  1/DATA_WIDTH/1: port 1 completion, read data, error.
REQ-009 SHALL have AXI-lite master AR: m_araddr out ADDR_WIDTH, m_arvalid out 1, m_arready in 1.
REQ-010 SHALL have AXI-lite master R: m_rdata in DATA_WIDTH, m_rresp in 2, m_rvalid in 1, m_rready out 1.
REQ-011 SHALL have AXI-lite master AW/W: m_awaddr out ADDR_WIDTH, m_awvalid out 1, m_awready in 1, m_wdata out DATA_WIDTH, m_wstrb out 8, m_wvalid out 1, m_wready in 1.
REQ-012 SHALL have AXI-lite master B: m_bresp in 2, m_bvalid in 1, m_bready out 1.

Function
REQ-013 SHALL implement FSM states IDLE, AR, R, AW, B, RESP; one transaction outstanding at a time.
REQ-014 IDLE: sample s0_req/s1_req; single requester granted; both -> grant port != last_grant; last_grant updated on every grant.
REQ-015 On grant SHALL latch owner, addr, we (port 0: we=0), wdata, wstrb; next state AR if we=0 else AW.
REQ-016 AR: m_arvalid=1, m_araddr=latched addr; on m_arready -> R.
REQ-017 R: m_rready=1; on m_rvalid latch m_rdata, err=(m_rresp!=0) -> RESP.
REQ-018 AW: m_awvalid and m_wvalid asserted from entry, each dropped independently after its own handshake; when both complete (same or different cycles) -> B.
REQ-019 B: m_bready=1; on m_bvalid latch err=(m_bresp!=0) -> RESP.
REQ-020 RESP: owner's sN_done=1 for exactly one cycle with registered rdata (0 for writes) and err; other port's done=0; next state IDLE.
REQ-021 Requester req still high in the IDLE cycle after done SHALL be treated as a new request.
REQ-022 Minimum latency req (IDLE cycle N) -> done: read N+3 with zero-wait slave; write N+3 with zero-wait slave.
REQ-023 Master valids SHALL stay asserted until handshake; requester inputs ignored outside IDLE.
REQ-024 s*_rdata/s*_err SHALL hold last value when done=0; only done is qualifying.

Reset
REQ-025 rst=0 at a clock edge: state=IDLE, last_grant=1 (port 0 wins first contention), all m_*valid, m_rready, m_bready, s*_done, s*_err = 0, s*_rdata = 0.
REQ-026 Reset mid-transaction SHALL abandon the transfer without done; slave is reset in the same domain.

Structure
REQ-027 State encodings, OKAY=2'b00 resp constant and port indices SHALL live in shared package mem_arb_pkg.
REQ-028 Two-way round-robin grant SHALL be a sub-module rr_arbiter2 (req[1:0], last, grant[1:0]).

Verification
REQ-029 s0_req only, addr 0x80000000, slave returns 0x1122334455667788 OKAY zero-wait -> m_arvalid at N+1, s0_done at N+3 with that data, s0_err=0.
REQ-030 s0_req and s1_req same cycle after reset -> port 0 served first, port 1 next; repeated contention alternates 0,1,0,1.
REQ-031 s1 write addr 0xa00003f8, wdata 0x41, wstrb 0x01, awready 2 cycles before wready -> awvalid drops first, wvalid held, single B, s1_done once, s1_rdata=0.
REQ-032 Same-cycle awready and wready -> direct AW->B, no re-issued valid.
REQ-033 Slave rresp=2'b10 on s1 read -> s1_err=1 in done cycle, s0 unaffected.
REQ-034 rst=0 while in R with m_rvalid pending -> next cycle IDLE, all outputs 0, no done pulse.
